// File: rtl/n_term_cfg_pkg.sv
// ---------------------------------------------------------------------------
// n_term_cfg_pkg
// Shared definitions for the north-edge turnaround tile (n_term_single2_cfg):
//   - state_e    : configuration FSM states (IDLE / WRITE / COMMIT)
//   - NUM_FRAMES : number of shadow frames actually backed by storage
//   - sel_e      : 2-bit per-output turnaround select encodings
// ---------------------------------------------------------------------------
package n_term_cfg_pkg;

    // Only the first three frames of a column carry configuration for this tile.
    localparam int NUM_FRAMES = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Per-output select: tie low, pass the same-index wire, pass the
    // next wire in the group (wrapping), or tie high.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_SAME = 2'd1,
        SEL_NEXT = 2'd2,
        SEL_ONE  = 2'd3
    } sel_e;

endpackage

// File: rtl/n_term_single2_cfg_if.sv
// ---------------------------------------------------------------------------
// n_term_single2_cfg_if
// Frame configuration bus for n_term_single2_cfg.
//   FrameData   : frame payload (DataWidth bits)
//   FrameAddr   : frame index within the column (AddrWidth bits)
//   FrameValid  : frame offered by the loader
//   FrameReady  : tile can accept a frame this cycle
//   FrameCommit : request a shadow-to-active copy
//   ConfigBusy  : commit in progress
//   FrameErr    : one-cycle pulse after a frame with an unbacked address
// Modports: master = configuration loader, slave = tile.
// ---------------------------------------------------------------------------
interface n_term_single2_cfg_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
);
    logic [DataWidth-1:0] FrameData;
    logic [AddrWidth-1:0] FrameAddr;
    logic                 FrameValid;
    logic                 FrameReady;
    logic                 FrameCommit;
    logic                 ConfigBusy;
    logic                 FrameErr;

    modport master (
        output FrameData, FrameAddr, FrameValid, FrameCommit,
        input  FrameReady, ConfigBusy, FrameErr
    );

    modport slave (
        input  FrameData, FrameAddr, FrameValid, FrameCommit,
        output FrameReady, ConfigBusy, FrameErr
    );
endinterface

// File: rtl/n_term_turn_mux.sv
// ---------------------------------------------------------------------------
// n_term_turn_mux
// Turnaround multiplexer for one wire group of Width bits.
//   src_i : northbound wires of the group
//   sel_i : 2-bit select per output, output i uses sel_i[2i+1:2i]
//   out_o : southbound wires of the group
// Select meanings: 0 = constant 0, 1 = src_i[i], 2 = src_i[(i+1) mod Width],
// 3 = constant 1.
// ---------------------------------------------------------------------------
module n_term_turn_mux
    import n_term_cfg_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic [Width-1:0]   src_i,
    input  logic [2*Width-1:0] sel_i,
    output logic [Width-1:0]   out_o
);

    // src_next[i] holds src_i[(i+1) mod Width]: a one-place rotate right.
    logic [Width-1:0] src_next;

    assign src_next = {src_i[0], src_i[Width-1:1]};

    always_comb begin
        out_o = '0;
        for (int i = 0; i < Width; i++) begin
            case (sel_e'(sel_i[2*i +: 2]))
                SEL_ZERO: out_o[i] = 1'b0;
                SEL_SAME: out_o[i] = src_i[i];
                SEL_NEXT: out_o[i] = src_next[i];
                SEL_ONE:  out_o[i] = 1'b1;
                default:  out_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/n_term_single2_cfg.sv
// ---------------------------------------------------------------------------
// n_term_single2_cfg
// North-edge termination tile: turns northbound wires around into southbound
// wires under control of a 72-bit active configuration register, loaded from
// a 3 x 32-bit shadow store that is written through a frame bus.
// Ports:
//   CLK, RESET            : clock, asynchronous active-high reset
//   N1END/N2MID/N2END/N4END : northbound wires arriving at the top edge
//   S1BEG/S2BEG/S2BEGb/S4BEG : turned-around southbound wires
//   frame_bus (slave)     : frame load / commit handshake
// Build option: define N_TERM_REGISTERED_OUT_EN to register all S outputs
// (one cycle of latency, reset to 0); otherwise they are combinational.
// ---------------------------------------------------------------------------
module n_term_single2_cfg
    import n_term_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 72
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  N1END,
    input  logic [7:0]  N2MID,
    input  logic [7:0]  N2END,
    input  logic [15:0] N4END,
    output logic [3:0]  S1BEG,
    output logic [7:0]  S2BEG,
    output logic [7:0]  S2BEGb,
    output logic [15:0] S4BEG,
    n_term_single2_cfg_if.slave frame_bus
);

    localparam int FrameIdxW = $clog2(NUM_FRAMES);

    state_e state_q, state_d;
    logic [NUM_FRAMES-1:0][FrameBitsPerRow-1:0] shadow_q, shadow_d;
    logic [NoConfigBits-1:0] active_q, active_d;
    logic frame_err_q, frame_err_d;

    logic frame_ready;
    logic config_busy;
    logic frame_accept;
    logic addr_is_shadow;
    logic addr_in_col;

    logic [3:0]  s1_beg_d;
    logic [7:0]  s2_beg_d;
    logic [7:0]  s2_begb_d;
    logic [15:0] s4_beg_d;

    assign addr_is_shadow = int'(frame_bus.FrameAddr) < NUM_FRAMES;
    assign addr_in_col    = int'(frame_bus.FrameAddr) < MaxFramesPerCol;

    // FSM: a commit request wins over frame traffic, and a frame offered in
    // the same cycle is still written, so the copy in COMMIT includes it.
    always_comb begin
        state_d      = state_q;
        frame_ready  = (state_q != ST_COMMIT);
        config_busy  = (state_q == ST_COMMIT);
        frame_accept = frame_bus.FrameValid && frame_ready;
        case (state_q)
            ST_IDLE: begin
                if (frame_bus.FrameCommit) begin
                    state_d = ST_COMMIT;
                end else if (frame_accept) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (frame_bus.FrameCommit) begin
                    state_d = ST_COMMIT;
                end else if (!frame_bus.FrameValid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Frames outside the shadow store (whether still inside the column or
    // beyond it) are swallowed and flagged. The active copy takes the low
    // NoConfigBits of the flattened shadow; the remaining bits are spare.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        frame_err_d = 1'b0;
        if (frame_accept) begin
            if (addr_is_shadow && addr_in_col) begin
                shadow_d[frame_bus.FrameAddr[FrameIdxW-1:0]] = frame_bus.FrameData;
            end else begin
                frame_err_d = 1'b1;
            end
        end
        if (config_busy) begin
            active_d = NoConfigBits'(shadow_q);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_bus.FrameReady = frame_ready;
    assign frame_bus.ConfigBusy = config_busy;
    assign frame_bus.FrameErr   = frame_err_q;

    n_term_turn_mux #(.Width(4)) u_mux_s1 (
        .src_i (N1END),
        .sel_i (active_q[7:0]),
        .out_o (s1_beg_d)
    );

    n_term_turn_mux #(.Width(8)) u_mux_s2 (
        .src_i (N2END),
        .sel_i (active_q[23:8]),
        .out_o (s2_beg_d)
    );

    n_term_turn_mux #(.Width(8)) u_mux_s2b (
        .src_i (N2MID),
        .sel_i (active_q[39:24]),
        .out_o (s2_begb_d)
    );

    n_term_turn_mux #(.Width(16)) u_mux_s4 (
        .src_i (N4END),
        .sel_i (active_q[71:40]),
        .out_o (s4_beg_d)
    );

`ifdef N_TERM_REGISTERED_OUT_EN
    logic [3:0]  s1_beg_q;
    logic [7:0]  s2_beg_q;
    logic [7:0]  s2_begb_q;
    logic [15:0] s4_beg_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_beg_q  <= '0;
            s2_beg_q  <= '0;
            s2_begb_q <= '0;
            s4_beg_q  <= '0;
        end else begin
            s1_beg_q  <= s1_beg_d;
            s2_beg_q  <= s2_beg_d;
            s2_begb_q <= s2_begb_d;
            s4_beg_q  <= s4_beg_d;
        end
    end

    assign S1BEG  = s1_beg_q;
    assign S2BEG  = s2_beg_q;
    assign S2BEGb = s2_begb_q;
    assign S4BEG  = s4_beg_q;
`else
    assign S1BEG  = s1_beg_d;
    assign S2BEG  = s2_beg_d;
    assign S2BEGb = s2_begb_d;
    assign S4BEG  = s4_beg_d;
`endif

endmodule
